// File: rtl/muldiv_seq.sv
// muldiv_seq: sequences mul/div requests to an external unit, with a fast path for trivial results, a timeout and flush
module muldiv_seq #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   output logic        unit_start,
   output logic        unit_kill,
   output logic [1:0]  unit_operator,
   output logic [1:0]  unit_signed_mode,
   output logic [31:0] unit_op_a,
   output logic [31:0] unit_op_b,
   input  logic        unit_done,
   input  logic [31:0] unit_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_err,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   state_e      state_q;
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q, res_q, res_d;
   logic        err_q;
   logic [7:0]  cnt_q;
   logic        accept, is_div, is_rem, b_zero, ovf, fast, timeout;
   assign req_ready = ~nrst & (state_q == IDLE) & ~flush;
   assign accept    = req_valid & req_ready;
   assign is_div    = req_op[3:2] == 2'b10;
   assign is_rem    = req_op[3:2] == 2'b11;
   assign b_zero    = req_b == 32'h0;
   assign ovf       = (req_op[1:0] == 2'b01) & (req_a == 32'h8000_0000) & (req_b == 32'hFFFF_FFFF);
   assign fast      = (req_op == 4'b0000) | ((is_div | is_rem) & (b_zero | ovf));
   // Result of a request that never reaches the unit; NOP and the unit path both start from zero
   assign res_d     = ~req_op[3] ? 32'h0 :
                      b_zero ? (is_rem ? req_a : 32'hFFFF_FFFF) :
                      (is_rem ? 32'h0 : 32'h8000_0000);
   assign timeout   = (state_q == WAIT) & (cnt_q == LAST) & ~unit_done;
   assign unit_start = ~nrst & ~flush & (state_q == ISSUE);
   assign unit_kill  = ~nrst & (flush ? (state_q == ISSUE) | (state_q == WAIT) : timeout);
   assign rsp_valid  = ~nrst & ~flush & (state_q == RESP);
   assign busy       = ~nrst & (state_q != IDLE);
   assign unit_operator    = op_q[3:2];
   assign unit_signed_mode = (op_q[1:0] == 2'b01) ? 2'b11 : (op_q[1:0] == 2'b10) ? 2'b10 : 2'b00;
   assign unit_op_a  = a_q;
   assign unit_op_b  = b_q;
   assign rsp_result = res_q;
   assign rsp_err    = err_q;
   // Controller FSM: reset beats flush, flush beats every normal transition
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else if (flush) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               op_q    <= req_op;
               a_q     <= req_a;
               b_q     <= req_b;
               res_q   <= res_d;
               err_q   <= 1'b0;
               state_q <= fast ? RESP : ISSUE;
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q + 8'd1;
               if (unit_done) begin
                  res_q   <= unit_result;
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end else if (cnt_q == LAST) begin
                  res_q   <= '0;
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end
            end
            RESP: if (rsp_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
